mealy_share_arbiter: RTL and testbench

MEALY_SHARE_ARBITER -- requirements
Module: mealy_share_arbiter

---
 rtl/mealy_share_arbiter_pkg.sv | 25 ++
 rtl/mealy_share_arbiter_rr_pick.sv | 37 +++
 rtl/mealy_share_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mealy_share_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mealy_share_arbiter_pkg.sv
// Shared definitions for the Mealy detector share arbiter.
// Holds the controller state encoding and the clog2 width helper used to size
// the requester index and the per-frame y1/y2 counters.
package mealy_share_arbiter_pkg;

  // Controller states, binary encoded.
  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE   = 2'd0;  // waiting for any request
  localparam arb_state_t ST_CLEAR  = 2'd1;  // one-cycle detector clear, counters zeroed
  localparam arb_state_t ST_RUN    = 2'd2;  // FRAME_LEN serial bits into the detector
  localparam arb_state_t ST_REPORT = 2'd3;  // done pulse (or abort pulse), pointer advance

  // Width needed to hold values 0..value-1; never less than one bit so that
  // degenerate sizes still give a legal vector.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/mealy_share_arbiter_rr_pick.sv
// rr_pick: circular first-set search over the request vector, starting at ptr.
// Latency: purely combinational. Backpressure: none, result valid whenever any_o=1.
// Ports: req_i (request vector), ptr_i (search start), any_o (some request set),
//        onehot_o (selected requester, one-hot), idx_o (selected requester, binary).
module rr_pick
  import mealy_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req_i,
  input  logic [clog2(NREQ)-1:0] ptr_i,
  output logic                   any_o,
  output logic [NREQ-1:0]        onehot_o,
  output logic [clog2(NREQ)-1:0] idx_o
);

  localparam int IW = clog2(NREQ);

  always_comb begin
    logic [IW-1:0] cand;
    cand     = '0;
    any_o    = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    // Walk ptr, ptr+1, ... wrapping at NREQ; the first hit wins, so at most
    // one bit of onehot_o can ever be set.
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

// File: rtl/mealy_share_arbiter.sv
// Round-robin arbiter time-sharing one external Mealy detector among NREQ serial requesters.
// Latency: grant one cycle after req seen in IDLE, first bit one cycle later; frame = FRAME_LEN+3 cycles.
// Backpressure: requesters hold req until granted and advance bit_in the cycle after each bit_take.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   req, bit_in         per-requester level request and serial data bit
//   bit_take, gnt       one-hot bit strobe (RUN only) and one-hot grant (grant..REPORT)
//   fsm_x, fsm_clear    serial bit and synchronous clear towards the shared detector
//   fsm_y1, fsm_y2      combinational Mealy outputs returned by the detector
//   done, done_id       frame-complete pulse and index of the finished requester
//   y1_cnt, y2_cnt      y1/y2 high-cycle counts of the last completed frame
//   abort               (MEALY_ARB_ABORT_EN only) frame dropped by its requester
//
// Build option MEALY_ARB_ABORT_EN: a granted requester that drops req during RUN
// terminates its frame; abort pulses instead of done and the reported results
// are left untouched. Without the macro a mid-frame req drop is ignored.
module mealy_share_arbiter
  import mealy_share_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int FRAME_LEN = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NREQ-1:0]                  req,
  input  logic [NREQ-1:0]                  bit_in,
  output logic [NREQ-1:0]                  bit_take,
  output logic [NREQ-1:0]                  gnt,
  output logic                             fsm_x,
  output logic                             fsm_clear,
  input  logic                             fsm_y1,
  input  logic                             fsm_y2,
  output logic                             done,
  output logic [clog2(NREQ)-1:0]           done_id,
  output logic [clog2(FRAME_LEN+1)-1:0]    y1_cnt,
  output logic [clog2(FRAME_LEN+1)-1:0]    y2_cnt
`ifdef MEALY_ARB_ABORT_EN
  ,
  output logic                             abort
`endif
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(FRAME_LEN + 1);

  arb_state_t      state_q,   state_d;
  logic [NREQ-1:0] gnt_q,     gnt_d;
  logic [IW-1:0]   gidx_q,    gidx_d;
  logic [IW-1:0]   rr_ptr_q,  rr_ptr_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   y1_acc_q,  y1_acc_d;
  logic [CW-1:0]   y2_acc_q,  y2_acc_d;
  logic [IW-1:0]   done_id_q, done_id_d;
  logic [CW-1:0]   y1_cnt_q,  y1_cnt_d;
  logic [CW-1:0]   y2_cnt_q,  y2_cnt_d;
  logic            abort_q,   abort_d;

  logic            pick_any;
  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            last_bit;
  logic            req_dropped;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .any_o    (pick_any),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  assign last_bit = (bit_cnt_q == CW'(FRAME_LEN - 1));

`ifdef MEALY_ARB_ABORT_EN
  assign req_dropped = !req[gidx_q];
`else
  // Mid-frame request changes are ignored; the frame always runs to completion.
  assign req_dropped = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;
    bit_cnt_d = bit_cnt_q;
    y1_acc_d  = y1_acc_q;
    y2_acc_d  = y2_acc_q;
    done_id_d = done_id_q;
    y1_cnt_d  = y1_cnt_q;
    y2_cnt_d  = y2_cnt_q;
    abort_d   = abort_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_onehot;
          gidx_d  = pick_idx;
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        bit_cnt_d = '0;
        y1_acc_d  = '0;
        y2_acc_d  = '0;
        abort_d   = 1'b0;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        // The detector's outputs respond to this cycle's fsm_x, so they are
        // accumulated on the same edge that consumes the bit.
        y1_acc_d  = y1_acc_q + CW'(fsm_y1);
        y2_acc_d  = y2_acc_q + CW'(fsm_y2);
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (req_dropped) begin
          // Abort takes priority even on the last bit: results stay as they were.
          abort_d = 1'b1;
          state_d = ST_REPORT;
        end else if (last_bit) begin
          // Reported results include the final bit's detector response.
          done_id_d = gidx_q;
          y1_cnt_d  = y1_acc_d;
          y2_cnt_d  = y2_acc_d;
          state_d   = ST_REPORT;
        end
      end

      ST_REPORT: begin
        gnt_d    = '0;
        rr_ptr_d = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
        abort_d  = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        gnt_d   = '0;
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      bit_cnt_q <= '0;
      y1_acc_q  <= '0;
      y2_acc_q  <= '0;
      done_id_q <= '0;
      y1_cnt_q  <= '0;
      y2_cnt_q  <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      rr_ptr_q  <= rr_ptr_d;
      bit_cnt_q <= bit_cnt_d;
      y1_acc_q  <= y1_acc_d;
      y2_acc_q  <= y2_acc_d;
      done_id_q <= done_id_d;
      y1_cnt_q  <= y1_cnt_d;
      y2_cnt_q  <= y2_cnt_d;
      abort_q   <= abort_d;
    end
  end

  // Datapath outputs are gated by state so they are quiet outside RUN and
  // drop in the same cycle an asynchronous reset hits.
  assign gnt       = gnt_q;
  assign bit_take  = (state_q == ST_RUN) ? gnt_q : '0;
  assign fsm_x     = (state_q == ST_RUN) && bit_in[gidx_q];
  // The detector is held clear for the whole time system reset is asserted.
  assign fsm_clear = !reset_n || (state_q == ST_CLEAR);
  assign done      = (state_q == ST_REPORT) && !abort_q;
  assign done_id   = done_id_q;
  assign y1_cnt    = y1_cnt_q;
  assign y2_cnt    = y2_cnt_q;

`ifdef MEALY_ARB_ABORT_EN
  assign abort = (state_q == ST_REPORT) && abort_q;
`endif

endmodule

// File: tb/tb_mealy_share_arbiter.sv
module tb_mealy_share_arbiter;

  localparam int N = 4;
  localparam int F = 8;
`ifdef MEALY_ARB_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [3:0] req, bit_in, bit_take, gnt;
  logic       fsm_x, fsm_clear, fsm_y1, fsm_y2, done;
  logic [1:0] done_id;
  logic [3:0] y1_cnt, y2_cnt;
  logic       abort_s;

  // Second instance: long frame, detector outputs stuck high.
  logic [1:0] l_req, l_take, l_gnt;
  logic       l_x, l_clr, l_done, l_abort;
  logic [0:0] l_id;
  logic [7:0] l_y1, l_y2;

  mealy_share_arbiter #(.NREQ(N), .FRAME_LEN(F)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .bit_in(bit_in), .bit_take(bit_take),
    .gnt(gnt), .fsm_x(fsm_x), .fsm_clear(fsm_clear), .fsm_y1(fsm_y1), .fsm_y2(fsm_y2),
    .done(done), .done_id(done_id), .y1_cnt(y1_cnt), .y2_cnt(y2_cnt)
`ifdef MEALY_ARB_ABORT_EN
    , .abort(abort_s)
`endif
  );

  mealy_share_arbiter #(.NREQ(2), .FRAME_LEN(255)) u_dut_long (
    .clk(clk), .reset_n(reset_n), .req(l_req), .bit_in(2'b00), .bit_take(l_take),
    .gnt(l_gnt), .fsm_x(l_x), .fsm_clear(l_clr), .fsm_y1(1'b1), .fsm_y2(1'b1),
    .done(l_done), .done_id(l_id), .y1_cnt(l_y1), .y2_cnt(l_y2)
`ifdef MEALY_ARB_ABORT_EN
    , .abort(l_abort)
`endif
  );

`ifndef MEALY_ARB_ABORT_EN
  assign abort_s = 1'b0;
  assign l_abort = 1'b0;
`endif

  // Requester frames, sent LSB first. pat[0] is the stream 1,0,1,1,0,1,1,0.
  logic [7:0] pat [4] = '{8'h6D, 8'hFF, 8'h00, 8'hAA};
  int         ptr [4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset_n)                   ptr[i] <= 0;
      else if (fsm_clear && gnt[i])   ptr[i] <= 0;
      else if (bit_take[i])           ptr[i] <= ptr[i] + 1;
    end
  end

  always_comb begin
    bit_in = '0;
    for (int i = 0; i < 4; i++) begin
      if (ptr[i] < F) bit_in[i] = pat[i][ptr[i][2:0]];
    end
  end

  // Detector: y1 flags "11", y2 flags "10" (previous bit, current bit).
  logic prev = 1'b0;
  always @(posedge clk) prev <= fsm_clear ? 1'b0 : fsm_x;
  assign fsm_y1 = fsm_x & prev;
  assign fsm_y2 = prev & ~fsm_x;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Count positions k where (bit k-1, bit k) == (a, b), with bit -1 taken as 0.
  function automatic int pair_count(input logic [7:0] p, input logic a, input logic b);
    int   c;
    logic pr;
    c  = 0;
    pr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (pr == a && p[k] == b) c++;
      pr = p[k];
    end
    return c;
  endfunction

  // Frame timeline model: phase 0 idle, 1 grant/clear, 2..F+1 bits,
  // F+2 report, F+3 aborted-report.
  int m_phase = 0, m_owner = 0, m_rr = 0, m_id = 0, m_y1 = 0, m_y2 = 0;

  always @(negedge clk) begin
    logic [3:0] e_gnt, e_take;
    logic       e_x, run;
    if (!reset_n) begin
      m_phase = 0; m_rr = 0; m_id = 0; m_y1 = 0; m_y2 = 0;
    end
    run    = (m_phase >= 2) && (m_phase <= F + 1);
    e_gnt  = (m_phase != 0) ? 4'(1 << m_owner) : 4'h0;
    e_take = run ? e_gnt : 4'h0;
    e_x    = 1'b0;
    if (run) e_x = pat[m_owner][m_phase - 2];
    chk("gnt",       32'(gnt),       32'(e_gnt));
    chk("bit_take",  32'(bit_take),  32'(e_take));
    chk("fsm_x",     32'(fsm_x),     32'(e_x));
    chk("fsm_clear", 32'(fsm_clear), 32'(!reset_n || m_phase == 1));
    chk("done",      32'(done),      32'(m_phase == F + 2));
    chk("done_id",   32'(done_id),   m_id);
    chk("y1_cnt",    32'(y1_cnt),    m_y1);
    chk("y2_cnt",    32'(y2_cnt),    m_y2);
`ifdef MEALY_ARB_ABORT_EN
    chk("abort",     32'(abort_s),   32'(m_phase == F + 3));
`endif
    if (reset_n) begin
      if (m_phase == 0) begin
        if (req != 4'h0) begin
          for (int k = N - 1; k >= 0; k--)
            if (req[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
          m_phase = 1;
        end
      end else if (m_phase >= F + 2) begin
        m_rr    = (m_owner + 1) % N;
        m_phase = 0;
      end else if (run && ABORT_EN && !req[m_owner]) begin
        m_phase = F + 3;
      end else begin
        m_phase++;
        if (m_phase == F + 2) begin
          m_id = m_owner;
          m_y1 = pair_count(pat[m_owner], 1'b1, 1'b1);
          m_y2 = pair_count(pat[m_owner], 1'b1, 1'b0);
        end
      end
    end
  end

  task automatic step_to();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL wait_done: no done within %0d cycles", maxc);
    end
  endtask

  task automatic wait_clear(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (fsm_clear === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL wait_clear: no fsm_clear within %0d cycles", maxc);
    end
  endtask

  int t2_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    int  takes;
    bit  seen;
    reset_n = 1'b0;
    req     = 4'h0;
    l_req   = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single requester: latency and detector counts.
    req = 4'b0001;
    @(negedge clk); chk("t1_idle_gnt", 32'(gnt), 0);
    @(negedge clk); chk("t1_grant", 32'(gnt), 1); chk("t1_clear", 32'(fsm_clear), 1);
    @(negedge clk); chk("t1_take", 32'(bit_take), 1); chk("t1_x0", 32'(fsm_x), 1);
    wait_done(20);
    chk("t1_done_id", 32'(done_id), 0);
    chk("t1_y1", 32'(y1_cnt), 2);
    chk("t1_y2", 32'(y2_cnt), 3);
    step_to(); req = 4'h0;
    @(negedge clk); chk("t1_gnt_drop", 32'(gnt), 0);

    // All four requesting from a fresh pointer: 0,1,2,3,0.
    step_to(); reset_n = 1'b0;
    step_to(); reset_n = 1'b1; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(20);
      chk($sformatf("t2_order%0d", k), 32'(done_id), t2_exp[k]);
    end
    step_to(); req = 4'h0;

    // Pointer now 1: idx 2 then idx 3 while both pending.
    req = 4'b1100;
    wait_done(20); chk("t3_first", 32'(done_id), 2);
    wait_done(20); chk("t3_second", 32'(done_id), 3);
    step_to(); req = 4'h0;

    // Move the pointer off zero, then reset in RUN cycle 4 of idx 2's frame.
    req = 4'b0010;
    wait_done(20); chk("t4_pre", 32'(done_id), 1);
    step_to(); req = 4'b0100;
    wait_clear(20);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("t4_rst_gnt", 32'(gnt), 0);
    chk("t4_rst_take", 32'(bit_take), 0);
    chk("t4_rst_x", 32'(fsm_x), 0);
    chk("t4_rst_done", 32'(done), 0);
    chk("t4_rst_clear", 32'(fsm_clear), 1);
    step_to(); step_to();
    reset_n = 1'b1; req = 4'b1111;
    wait_done(20); chk("t4_after_rst", 32'(done_id), 0);
    step_to(); req = 4'h0;

    // Long frame with detector outputs stuck high: counts reach 255, no wrap.
    l_req = 2'b01;
    takes = 0;
    seen  = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (l_take[0]) takes++;
      if (l_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL t5_wait: no done on long frame within 300 cycles");
    end
    chk("t5_takes", takes, 255);
    chk("t5_y1", 32'(l_y1), 255);
    chk("t5_y2", 32'(l_y2), 255);
    chk("t5_id", 32'(l_id), 0);
    step_to(); l_req = 2'b00;

`ifdef MEALY_ARB_ABORT_EN
    // Requester 0 drops in RUN cycle 3; requester 1 follows.
    step_to(); reset_n = 1'b0;
    step_to(); reset_n = 1'b1; req = 4'b0011;
    wait_clear(20);
    repeat (3) @(posedge clk);
    #1 req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    chk("t6_abort", 32'(abort_s), 1);
    chk("t6_no_done", 32'(done), 0);
    wait_done(20); chk("t6_next", 32'(done_id), 1);
    step_to(); req = 4'h0;
`endif

    repeat (3) step_to();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
